// File: rtl/mi_sequencer.sv
// Fetch/decode/execute controller around the micro-instruction ROM.
// Runs memory handshakes and resolves jumps and BSR against ALU flags.
module mi_sequencer #(
   parameter int unsigned     AW       = 11,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter int unsigned     ACK_MAX  = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   input  logic [21:0]   mem_rdata,
   input  logic          mem_ack,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [21:0]   mi_instr,
   input  logic [32:0]   mi_word,
   input  logic          flag_z,
   input  logic          flag_cy,
   output logic [32:0]   ctrl_word,
   output logic          ctrl_valid,
   output logic [AW-1:0] pc,
   output logic          illegal,
   output logic          bus_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_ERR
   } state_e;

   typedef enum logic [3:0] {
      C_JMP, C_JZE, C_JNE, C_JCY, C_BSR,
      C_MOV, C_ADW, C_MOM, C_ILL
   } cls_e;

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW-1:0] link_q, link_d;
   logic [21:0]   instr_q, instr_d;
   logic [32:0]   ctrl_word_q, ctrl_word_d;
   logic          ctrl_valid_q, ctrl_valid_d;
   logic          illegal_q, illegal_d;
   logic          bus_err_q, bus_err_d;
   logic [3:0]    wait_q, wait_d;
   logic          mr_q, mr_d;
   logic          mw_q, mw_d;

   cls_e          cls;
   logic [10:0]   op11;
   logic [11:0]   op12;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] tgt_j;
   logic [AW-1:0] tgt_b;
   logic          tmo;
   state_e        fetch_nxt;

   assign op11   = instr_q[21:11];
   assign op12   = instr_q[21:10];
   assign pc_inc = pc_q + AW'(1);
   assign tgt_j  = instr_q[AW-1:0];
   assign tgt_b  = AW'(instr_q[9:0]);
   assign tmo    = (wait_q == 4'(ACK_MAX - 1));
   // Leaving an instruction only parks in IDLE when run has dropped
   assign fetch_nxt = run ? S_FETCH : S_IDLE;

   always_comb begin
      cls = C_ILL;
      unique case (1'b1)
         op11 == 11'h400: cls = C_JMP;
         op11 == 11'h500: cls = C_JZE;
         op11 == 11'h600: cls = C_JNE;
         op11 == 11'h700: cls = C_JCY;
         op12 == 12'h100: cls = C_MOV;
         op12 == 12'h180: cls = C_ADW;
         op12 == 12'h1C0: cls = C_BSR;
         op12 == 12'h200: cls = C_MOM;
         op12 == 12'h280: cls = C_MOM;
         default:         cls = C_ILL;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      link_d       = link_q;
      instr_d      = instr_q;
      ctrl_word_d  = '0;
      ctrl_valid_d = 1'b0;
      illegal_d    = 1'b0;
      bus_err_d    = bus_err_q;
      wait_d       = '0;
      mr_d         = mr_q;
      mw_d         = mw_q;
      mem_addr     = pc_q;
      mem_rd       = 1'b0;
      mem_wr       = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run && !bus_err_q) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ack) begin
               instr_d = mem_rdata;
               state_d = S_DECODE;
            end else if (tmo) begin
               bus_err_d = 1'b1;
               state_d   = S_ERR;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_DECODE: begin
            if (cls == C_ILL) begin
               illegal_d = 1'b1;
               pc_d      = pc_inc;
               state_d   = fetch_nxt;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            pc_d    = pc_inc;
            state_d = fetch_nxt;
            unique case (cls)
               C_JMP: pc_d = tgt_j;
               C_JZE: if (flag_z) pc_d = tgt_j;
               C_JNE: if (!flag_z) pc_d = tgt_j;
               C_JCY: if (flag_cy) pc_d = tgt_j;
               C_BSR: begin
                  link_d = pc_inc;
                  pc_d   = tgt_b;
               end
               default: begin
                  if (mi_word[25] && mi_word[24]) begin
                     illegal_d = 1'b1;
                  end else begin
                     ctrl_word_d  = mi_word;
                     ctrl_valid_d = 1'b1;
                     if (mi_word[25] || mi_word[24]) begin
                        mr_d    = mi_word[25];
                        mw_d    = mi_word[24];
                        pc_d    = pc_q;
                        state_d = S_MEM;
                     end
                  end
               end
            endcase
         end
         S_MEM: begin
            mem_addr = tgt_b;
            mem_rd   = mr_q;
            mem_wr   = mw_q;
            if (mem_ack) begin
               pc_d    = pc_inc;
               state_d = fetch_nxt;
            end else if (tmo) begin
               bus_err_d = 1'b1;
               state_d   = S_ERR;
            end else begin
               wait_d = wait_q + 4'd1;
            end
         end
         S_ERR: state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         link_q       <= '0;
         instr_q      <= '0;
         ctrl_word_q  <= '0;
         ctrl_valid_q <= 1'b0;
         illegal_q    <= 1'b0;
         bus_err_q    <= 1'b0;
         wait_q       <= '0;
         mr_q         <= 1'b0;
         mw_q         <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         link_q       <= link_d;
         instr_q      <= instr_d;
         ctrl_word_q  <= ctrl_word_d;
         ctrl_valid_q <= ctrl_valid_d;
         illegal_q    <= illegal_d;
         bus_err_q    <= bus_err_d;
         wait_q       <= wait_d;
         mr_q         <= mr_d;
         mw_q         <= mw_d;
      end
   end

   assign mi_instr   = instr_q;
   assign ctrl_word  = ctrl_word_q;
   assign ctrl_valid = ctrl_valid_q;
   assign pc         = pc_q;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mi_sequencer.sv
// Scoreboard bench for mi_sequencer: memory/ROM models, directed
// programs, expected event queue drained by an independent monitor.
module tb_mi_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [21:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic [10:0] mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [21:0] mi_instr;
   logic [32:0] mi_word;
   logic        flag_z;
   logic        flag_cy;
   logic [32:0] ctrl_word;
   logic        ctrl_valid;
   logic [10:0] pc;
   logic        illegal;
   logic        bus_err;

   always #5 clk = ~clk;

   mi_sequencer dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mi_instr(mi_instr), .mi_word(mi_word),
      .flag_z(flag_z), .flag_cy(flag_cy),
      .ctrl_word(ctrl_word), .ctrl_valid(ctrl_valid),
      .pc(pc), .illegal(illegal), .bus_err(bus_err)
   );

   // ROM words: {ALU4,SH2,Kmx,MR,MW,BusB6,BusC6,T7,BusA5}
   localparam logic [32:0] ADW_W =
      {4'b0101, 2'b00, 1'b0, 1'b0, 1'b0,
       6'd7, 6'd3, 7'b0111101, 5'd3};
   localparam logic [32:0] MOV_W =
      {4'b0000, 2'b01, 1'b0, 1'b0, 1'b0,
       6'd1, 6'd2, 7'h40, 5'd4};
   localparam logic [32:0] LD_W =
      {4'b0011, 2'b00, 1'b0, 1'b1, 1'b0,
       6'd2, 6'd5, 7'd9, 5'd1};
   localparam logic [32:0] ST_W =
      {4'b0000, 2'b00, 1'b1, 1'b0, 1'b1,
       6'd4, 6'd0, 7'd0, 5'd2};
   localparam logic [32:0] BOTH_W =
      {4'b0000, 2'b00, 1'b0, 1'b1, 1'b1, 24'd0};
   localparam logic [32:0] JUNK_W = 33'h1_2345_6789;

   function automatic logic [32:0] rom_f(input logic [21:0] i);
      if (i[21:10] == 12'h180) return ADW_W;
      if (i[21:10] == 12'h100) return MOV_W;
      if (i[21:10] == 12'h200) return ST_W;
      if (i[21:10] == 12'h280)
         return (i[9:0] == 10'h3FF) ? BOTH_W : LD_W;
      return JUNK_W;
   endfunction

   always_comb mi_word = rom_f(mi_instr);

   function automatic logic [21:0] op_j(
      input logic [10:0] op, input logic [10:0] t);
      return {op, t};
   endfunction

   function automatic logic [21:0] op_a(
      input logic [11:0] op, input logic [9:0] a);
      return {op, a};
   endfunction

   function automatic logic [34:0] evm(
      input logic [10:0] a, input logic rd,
      input logic wr, input logic [3:0] c);
      return {2'd0, 16'd0, c, rd, wr, a};
   endfunction

   function automatic logic [34:0] evc(input logic [32:0] w);
      return {2'd1, w};
   endfunction

   function automatic logic [34:0] evi(input logic [10:0] p);
      return {2'd2, 22'd0, p};
   endfunction

   int          vectors = 0;
   int          miscompares = 0;
   logic [34:0] exp_q[$];
   logic        armed = 1'b0;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   // Program memory with configurable ack latency
   logic [21:0] prog [0:2047];
   int          lat = 0;
   logic [11:0] noack = 12'hFFF;
   int          req_cyc = 0;
   logic        ack_pend = 1'b0;
   logic [34:0] ack_ev = '0;

   always @(negedge clk) begin
      mem_ack  = 1'b0;
      ack_pend = 1'b0;
      if (rst_n && (mem_rd || mem_wr)) begin
         req_cyc = req_cyc + 1;
         if ({1'b0, mem_addr} != noack &&
             req_cyc == lat + 1) begin
            mem_ack   = 1'b1;
            mem_rdata = prog[mem_addr];
            ack_ev    = evm(mem_addr, mem_rd, mem_wr,
                            4'(req_cyc));
            ack_pend  = 1'b1;
            req_cyc   = 0;
         end
      end else begin
         req_cyc = 0;
      end
   end

   task automatic got(input logic [34:0] ev,
                      input string nm);
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL %s unexpected: got %h required none",
                  nm, ev);
      end else begin
         chk(nm, 64'(ev), 64'(exp_q.pop_front()));
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (armed) begin
            if (ack_pend)   got(ack_ev, "mem_ack");
            if (ctrl_valid) got(evc(ctrl_word), "ctrl");
            if (illegal)    got(evi(pc), "illegal");
         end
      end
   end

   task automatic reset_dut();
      @(negedge clk);
      rst_n = 1'b0;
      run   = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic drain(input string nm);
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      armed = 1'b0;
      chk(nm, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      int cnt;
      rst_n   = 1'b0;
      run     = 1'b0;
      flag_z  = 1'b0;
      flag_cy = 1'b0;
      for (int i = 0; i < 2048; i++) prog[i] = '0;

      reset_dut();
      chk("rst_pc", 64'(pc), 64'd0);
      chk("rst_rd", 64'(mem_rd), 64'd0);
      chk("rst_wr", 64'(mem_wr), 64'd0);
      chk("rst_cv", 64'(ctrl_valid), 64'd0);
      chk("rst_ill", 64'(illegal), 64'd0);
      chk("rst_berr", 64'(bus_err), 64'd0);
      chk("rst_instr", 64'(mi_instr), 64'd0);
      chk("rst_cw", 64'(ctrl_word), 64'd0);

      // Segment A: zero-wait memory, z=1 cy=0
      prog[11'h000] = op_j(11'h400, 11'h05A);
      prog[11'h05A] = op_j(11'h500, 11'h010);
      prog[11'h010] = op_j(11'h600, 11'h020);
      prog[11'h011] = op_j(11'h700, 11'h030);
      prog[11'h012] = op_a(12'h180, 10'h037);
      prog[11'h013] = 22'h3FFFFF;
      prog[11'h014] = op_a(12'h280, 10'h02A);
      prog[11'h015] = op_a(12'h200, 10'h02B);
      prog[11'h016] = op_a(12'h1C0, 10'h100);
      prog[11'h100] = op_a(12'h280, 10'h3FF);
      prog[11'h101] = op_j(11'h400, 11'h7FF);
      prog[11'h7FF] = op_a(12'h100, 10'h021);
      flag_z  = 1'b1;
      flag_cy = 1'b0;
      lat     = 0;
      exp_q.push_back(evm(11'h000, 1, 0, 1));
      exp_q.push_back(evm(11'h05A, 1, 0, 1));
      exp_q.push_back(evm(11'h010, 1, 0, 1));
      exp_q.push_back(evm(11'h011, 1, 0, 1));
      exp_q.push_back(evm(11'h012, 1, 0, 1));
      exp_q.push_back(evc(ADW_W));
      exp_q.push_back(evm(11'h013, 1, 0, 1));
      exp_q.push_back(evi(11'h014));
      exp_q.push_back(evm(11'h014, 1, 0, 1));
      exp_q.push_back(evc(LD_W));
      exp_q.push_back(evm(11'h02A, 1, 0, 1));
      exp_q.push_back(evm(11'h015, 1, 0, 1));
      exp_q.push_back(evc(ST_W));
      exp_q.push_back(evm(11'h02B, 0, 1, 1));
      exp_q.push_back(evm(11'h016, 1, 0, 1));
      exp_q.push_back(evm(11'h100, 1, 0, 1));
      exp_q.push_back(evi(11'h101));
      exp_q.push_back(evm(11'h101, 1, 0, 1));
      exp_q.push_back(evm(11'h7FF, 1, 0, 1));
      exp_q.push_back(evc(MOV_W));
      exp_q.push_back(evm(11'h000, 1, 0, 1));
      armed = 1'b1;
      rst_n = 1'b1;
      run   = 1'b1;
      @(posedge clk);
      #1;
      chk("first_fetch", 64'({mem_rd, mem_addr}),
          64'({1'b1, 11'h000}));
      drain("drain_a");

      // Segment B: 3-cycle memory, z=0 cy=1
      reset_dut();
      prog[11'h000] = op_j(11'h500, 11'h010);
      prog[11'h001] = op_j(11'h600, 11'h010);
      prog[11'h010] = op_j(11'h700, 11'h020);
      prog[11'h020] = op_a(12'h280, 10'h02A);
      prog[11'h021] = op_j(11'h400, 11'h021);
      flag_z  = 1'b0;
      flag_cy = 1'b1;
      lat     = 2;
      exp_q.push_back(evm(11'h000, 1, 0, 3));
      exp_q.push_back(evm(11'h001, 1, 0, 3));
      exp_q.push_back(evm(11'h010, 1, 0, 3));
      exp_q.push_back(evm(11'h020, 1, 0, 3));
      exp_q.push_back(evc(LD_W));
      exp_q.push_back(evm(11'h02A, 1, 0, 3));
      exp_q.push_back(evm(11'h021, 1, 0, 3));
      armed = 1'b1;
      rst_n = 1'b1;
      run   = 1'b1;
      drain("drain_b");

      // Segment C: fetch never acked -> timeout
      reset_dut();
      lat   = 0;
      noack = 12'h000;
      rst_n = 1'b1;
      run   = 1'b1;
      cnt   = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (bus_err) break;
         if (mem_rd) cnt++;
      end
      chk("tmo_cycles", 64'(cnt), 64'd15);
      chk("tmo_berr", 64'(bus_err), 64'd1);
      chk("tmo_rd", 64'(mem_rd), 64'd0);
      repeat (5) @(posedge clk);
      #1;
      chk("berr_sticky", 64'({bus_err, mem_rd}), 64'b10);

      // Segment D: reset while a load waits in MEM
      reset_dut();
      chk("berr_clr", 64'(bus_err), 64'd0);
      noack = 12'h02A;
      prog[11'h000] = op_a(12'h280, 10'h02A);
      rst_n = 1'b1;
      run   = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (mem_rd && mem_addr == 11'h02A) break;
      end
      chk("mem_phase", 64'({mem_rd, mem_wr, mem_addr}),
          64'({2'b10, 11'h02A}));
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_mem_req", 64'({mem_rd, mem_wr}), 64'd0);
      chk("rst_mem_pc", 64'(pc), 64'd0);
      chk("rst_mem_ir", 64'(mi_instr), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
